// File: rtl/ascon_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ascon_pack : ASCON state type, S-box and round constants. Rev 1.0
// ---------------------------------------------------------------------------
package ascon_pack;

    // Word 0 (x0) occupies the most significant 64 bits of the packed vector.
    typedef logic [0:4][63:0] type_state;

    localparam int unsigned C_NUM_ROUNDS = 12;

    function automatic logic [4:0] ascon_sbox(input logic [4:0] i_col);
        logic [4:0] v_out;
        case (i_col)
            5'd0:  v_out = 5'h04;
            5'd1:  v_out = 5'h0B;
            5'd2:  v_out = 5'h1F;
            5'd3:  v_out = 5'h14;
            5'd4:  v_out = 5'h1A;
            5'd5:  v_out = 5'h15;
            5'd6:  v_out = 5'h09;
            5'd7:  v_out = 5'h02;
            5'd8:  v_out = 5'h1B;
            5'd9:  v_out = 5'h05;
            5'd10: v_out = 5'h08;
            5'd11: v_out = 5'h12;
            5'd12: v_out = 5'h1D;
            5'd13: v_out = 5'h03;
            5'd14: v_out = 5'h06;
            5'd15: v_out = 5'h1C;
            5'd16: v_out = 5'h1E;
            5'd17: v_out = 5'h13;
            5'd18: v_out = 5'h07;
            5'd19: v_out = 5'h0E;
            5'd20: v_out = 5'h00;
            5'd21: v_out = 5'h0D;
            5'd22: v_out = 5'h11;
            5'd23: v_out = 5'h18;
            5'd24: v_out = 5'h10;
            5'd25: v_out = 5'h0C;
            5'd26: v_out = 5'h01;
            5'd27: v_out = 5'h19;
            5'd28: v_out = 5'h16;
            5'd29: v_out = 5'h0A;
            5'd30: v_out = 5'h0F;
            default: v_out = 5'h17;
        endcase
        return v_out;
    endfunction

    // Rounds 12..15 are outside the schedule and add nothing.
    function automatic logic [7:0] round_const(input logic [3:0] i_round);
        logic [3:0] v_hi;
        v_hi = 4'hF - i_round;
        return (i_round < 4'd12) ? {v_hi, i_round} : 8'h00;
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] i_x, input int unsigned i_n);
        return (i_x >> i_n) | (i_x << (64 - i_n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ascon_round : one combinational ASCON round (pc, ps, pl). Rev 1.0
// ---------------------------------------------------------------------------
module ascon_round
    import ascon_pack::*;
(
    input  type_state  i_state,
    input  logic [3:0] i_round,
    output type_state  o_state
);

    type_state w_pc;
    type_state w_ps;

    always_comb begin
        w_pc          = i_state;
        w_pc[2][7:0]  = i_state[2][7:0] ^ round_const(i_round);
    end

    // Each bit position forms a 5-bit column with x0 as the MSB.
    always_comb begin : p_sbox
        logic [4:0] w_col;
        w_ps  = '0;
        w_col = '0;
        for (int i = 0; i < 64; i++) begin
            w_col      = ascon_sbox({w_pc[0][i], w_pc[1][i], w_pc[2][i], w_pc[3][i], w_pc[4][i]});
            w_ps[0][i] = w_col[4];
            w_ps[1][i] = w_col[3];
            w_ps[2][i] = w_col[2];
            w_ps[3][i] = w_col[1];
            w_ps[4][i] = w_col[0];
        end
    end

    always_comb begin
        o_state[0] = w_ps[0] ^ ror64(w_ps[0], 19) ^ ror64(w_ps[0], 28);
        o_state[1] = w_ps[1] ^ ror64(w_ps[1], 61) ^ ror64(w_ps[1], 39);
        o_state[2] = w_ps[2] ^ ror64(w_ps[2], 1)  ^ ror64(w_ps[2], 6);
        o_state[3] = w_ps[3] ^ ror64(w_ps[3], 10) ^ ror64(w_ps[3], 17);
        o_state[4] = w_ps[4] ^ ror64(w_ps[4], 7)  ^ ror64(w_ps[4], 41);
    end

endmodule
`default_nettype wire

// File: rtl/permutation_v2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// permutation_v2 : registered ASCON round with AEAD mode XORs. Rev 1.0
// ---------------------------------------------------------------------------
module permutation_v2
    import ascon_pack::*;
(
    input  logic         clock_i,
    input  logic         resetb_i,
    input  type_state    state_i,
    input  logic         data_sel_i,
    input  logic [3:0]   round_i,
    input  logic         en_xor_data_i,
    input  logic         en_xor_key_i,
    input  logic         en_xor_key_end_i,
    input  logic         en_xor_lsb_i,
    input  logic         en_reg_state_i,
    input  logic [63:0]  data_i,
    input  logic [127:0] key_i,
    output type_state    state_o
);

    type_state r_state;
    type_state w_mux;
    type_state w_begin;
    type_state w_round;
    type_state w_end;

    assign w_mux = data_sel_i ? state_i : r_state;

    always_comb begin
        w_begin = w_mux;
        if (en_xor_data_i) begin
            w_begin[0] = w_mux[0] ^ data_i;
        end
        if (en_xor_key_i) begin
            w_begin[1] = w_mux[1] ^ key_i[127:64];
            w_begin[2] = w_mux[2] ^ key_i[63:0];
        end
    end

    ascon_round u_round (
        .i_state (w_begin),
        .i_round (round_i),
        .o_state (w_round)
    );

    // The domain-separation bit is applied after the key so the two compose.
    always_comb begin
        w_end = w_round;
        if (en_xor_key_end_i) begin
            w_end[3] = w_round[3] ^ key_i[127:64];
            w_end[4] = w_round[4] ^ key_i[63:0];
        end
        if (en_xor_lsb_i) begin
            w_end[4] = w_end[4] ^ 64'd1;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= '0;
        end else if (en_reg_state_i) begin
            r_state <= w_end;
        end
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_permutation_v2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_permutation_v2 : random and directed bench with a word-level ASCON model.
// ---------------------------------------------------------------------------
module tb_permutation_v2;
    import ascon_pack::*;

    logic         clock_i = 1'b0;
    logic         resetb_i;
    type_state    state_i;
    logic         data_sel_i;
    logic [3:0]   round_i;
    logic         en_xor_data_i;
    logic         en_xor_key_i;
    logic         en_xor_key_end_i;
    logic         en_xor_lsb_i;
    logic         en_reg_state_i;
    logic [63:0]  data_i;
    logic [127:0] key_i;
    type_state    state_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit [63:0] m[5];

    always #5 clock_i = ~clock_i;

    permutation_v2 dut (
        .clock_i          (clock_i),
        .resetb_i         (resetb_i),
        .state_i          (state_i),
        .data_sel_i       (data_sel_i),
        .round_i          (round_i),
        .en_xor_data_i    (en_xor_data_i),
        .en_xor_key_i     (en_xor_key_i),
        .en_xor_key_end_i (en_xor_key_end_i),
        .en_xor_lsb_i     (en_xor_lsb_i),
        .en_reg_state_i   (en_reg_state_i),
        .data_i           (data_i),
        .key_i            (key_i),
        .state_o          (state_o)
    );

    task automatic chk_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [63:0] rotr(input bit [63:0] x, input int n);
        bit [127:0] t;
        t = {x, x} >> n;
        return t[63:0];
    endfunction

    function automatic bit [63:0] lin(input bit [63:0] x, input int a, input int b);
        return x ^ rotr(x, a) ^ rotr(x, b);
    endfunction

    function automatic bit [319:0] model_vec();
        return {m[0], m[1], m[2], m[3], m[4]};
    endfunction

    // Reference round in the bitsliced form of the ASCON reference code.
    task automatic model_clock();
        bit [63:0] x[5];
        bit [63:0] t[5];
        if (en_reg_state_i) begin
            for (int k = 0; k < 5; k++) x[k] = data_sel_i ? state_i[k] : m[k];
            if (en_xor_data_i) x[0] ^= data_i;
            if (en_xor_key_i) begin
                x[1] ^= key_i[127:64];
                x[2] ^= key_i[63:0];
            end
            if (round_i < 4'd12) x[2] ^= 64'(240 - 15 * int'(round_i));
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
            for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            x[0] = lin(x[0], 19, 28);
            x[1] = lin(x[1], 61, 39);
            x[2] = lin(x[2], 1, 6);
            x[3] = lin(x[3], 10, 17);
            x[4] = lin(x[4], 7, 41);
            if (en_xor_key_end_i) begin
                x[3] ^= key_i[127:64];
                x[4] ^= key_i[63:0];
            end
            if (en_xor_lsb_i) x[4] ^= 64'd1;
            for (int k = 0; k < 5; k++) m[k] = x[k];
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clock_i);
        model_clock();
        #1;
        chk_eq(tag, state_o, model_vec());
    endtask

    task automatic ctrl(input bit sel, input int r, input bit xd, input bit xk,
                        input bit xke, input bit xl, input bit en);
        data_sel_i       = sel;
        round_i          = 4'(r);
        en_xor_data_i    = xd;
        en_xor_key_i     = xk;
        en_xor_key_end_i = xke;
        en_xor_lsb_i     = xl;
        en_reg_state_i   = en;
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < 5; k++) state_i[k] = {$urandom, $urandom};
        data_i = {$urandom, $urandom};
        key_i  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        bit [319:0] golden;
        rand_inputs();
        ctrl(1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        resetb_i = 1'b0;
        for (int k = 0; k < 5; k++) m[k] = '0;
        #1;
        chk_eq("reset_async", state_o, '0);
        repeat (3) begin
            @(posedge clock_i);
            #1;
            chk_eq("reset_hold", state_o, '0);
        end
        resetb_i = 1'b1;

        // Single round from the all-zero state.
        state_i = '0;
        ctrl(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("round0_model");
        golden = {lin(64'hF0, 19, 28), lin(64'hF0, 61, 39), lin(64'hFFFF_FFFF_FFFF_FF0F, 1, 6),
                  lin(64'hF0, 10, 17), 64'h0};
        chk_eq("round0_golden", state_o, golden);

        ctrl(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            rand_inputs();
            round_i = 4'($urandom_range(0, 15));
            cycle("hold");
        end

        // ASCON-128 initialisation: pa with the key folded in at the end.
        state_i[0] = 64'h80400c0600000000;
        state_i[1] = 64'h0001020304050607;
        state_i[2] = 64'h08090a0b0c0d0e0f;
        state_i[3] = 64'h0011223344556677;
        state_i[4] = 64'h8899aabbccddeeff;
        key_i      = 128'h000102030405060708090A0B0C0D0E0F;
        data_i     = 64'h3230323380000000;
        for (int r = 0; r < 12; r++) begin
            ctrl(r == 0, r, 1'b0, 1'b0, r == 11, 1'b0, 1'b1);
            cycle($sformatf("init_r%0d", r));
        end

        // pb with begin-XOR enables both, data only, key only.
        for (int mode = 0; mode < 3; mode++) begin
            for (int r = 6; r < 12; r++) begin
                ctrl(1'b0, r, (r == 6) && (mode != 2), (r == 6) && (mode != 1), 1'b0, 1'b0, 1'b1);
                cycle($sformatf("pb_mode%0d_r%0d", mode, r));
            end
        end

        // End-XOR combinations.
        ctrl(1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); cycle("end_key_lsb");
        ctrl(1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); cycle("end_lsb");
        ctrl(1'b0, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); cycle("end_key");

        // Out-of-schedule round indices add no constant.
        rand_inputs();
        for (int r = 12; r < 16; r++) begin
            ctrl(1'b1, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cycle($sformatf("rc_zero_r%0d", r));
        end

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            ctrl($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 4) != 0);
            cycle("random");
        end

        // Abort a running permutation with reset, then restart.
        rand_inputs();
        for (int r = 0; r < 3; r++) begin
            ctrl(r == 0, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cycle("pre_abort");
        end
        #2;
        resetb_i = 1'b0;
        for (int k = 0; k < 5; k++) m[k] = '0;
        #1;
        chk_eq("abort_async", state_o, '0);
        repeat (2) begin
            @(posedge clock_i);
            #1;
            chk_eq("abort_hold", state_o, '0);
        end
        resetb_i = 1'b1;
        for (int r = 0; r < 12; r++) begin
            ctrl(r == 0, r, 1'b0, 1'b0, r == 11, 1'b0, 1'b1);
            cycle("restart");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
